// File: rtl/iter_divmod_16b8b.sv
// iter_divmod_16b8b: 16/8 unsigned restoring divider resolving one quotient bit per cycle.
// Define DIVMOD_DIVZERO_FLAG_EN to add the divzero output flag.
module iter_divmod_16b8b (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [15:0] quot,
  output logic [7:0]  rem
`ifdef DIVMOD_DIVZERO_FLAG_EN
  ,
  output logic        divzero
`endif
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [16:0] r_rem;
  logic [15:0] r_quot;
  logic [7:0]  r_div;
  logic [17:0] w_shift;
  logic [16:0] w_sub;
  logic        w_ge;
  // r_quot shifts dividend bits out of the top while quotient bits enter at the bottom
  assign w_shift = {r_rem, r_quot[15]};
  assign w_ge    = w_shift >= {10'd0, r_div};
  assign w_sub   = w_shift[16:0] - {9'd0, r_div};
  assign in_rdy  = r_state == IDLE;
  assign out_val = r_state == DONE;
  assign quot    = r_quot;
  assign rem     = r_rem[7:0];
  always_comb begin
    w_next = (r_state == IDLE && in_val) ? CALC :
             (r_state == CALC && r_cnt == 4'd15) ? DONE :
             (r_state == DONE && out_rdy) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == CALC) ? r_cnt + 4'd1 : 4'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (r_state == IDLE && in_val) begin
      r_rem  <= 17'd0;
      r_quot <= dividend;
      r_div  <= divisor;
    end else if (r_state == CALC) begin
      r_rem  <= w_ge ? w_sub : w_shift[16:0];
      r_quot <= {r_quot[14:0], w_ge};
    end
  end
`ifdef DIVMOD_DIVZERO_FLAG_EN
  logic r_dz;
  assign divzero = r_dz;
  always_ff @(posedge clk) begin
    if (reset) r_dz <= 1'b0;
    else if (r_state == CALC && r_cnt == 4'd15) r_dz <= r_div == 8'd0;
    else if (r_state == DONE && out_rdy) r_dz <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_iter_divmod_16b8b.sv
// tb_iter_divmod_16b8b: table-driven checks of iter_divmod_16b8b plus backpressure, reset and random-traffic sequences.
module tb_iter_divmod_16b8b;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic [15:0] dividend = 16'd0;
  logic [7:0]  divisor = 8'd0;
  logic        out_val;
  logic        out_rdy = 1'b1;
  logic [15:0] quot;
  logic [7:0]  rem;
`ifdef DIVMOD_DIVZERO_FLAG_EN
  logic        divzero;
`endif
  int n_chk = 0;
  int n_err = 0;

  iter_divmod_16b8b dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
    .dividend(dividend), .divisor(divisor), .out_val(out_val), .out_rdy(out_rdy),
    .quot(quot), .rem(rem)
`ifdef DIVMOD_DIVZERO_FLAG_EN
    , .divzero(divzero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [15:0] q;
    logic [7:0]  r;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_req(input logic [15:0] dd, input logic [7:0] dv, output int lat);
    @(negedge clk);
    chk("req_in_rdy", in_rdy, 1);
    in_val = 1'b1;
    dividend = dd;
    divisor = dv;
    @(posedge clk);
    @(negedge clk);
    in_val = 1'b0;
    dividend = ~dd;
    divisor = ~dv;
    lat = 1;
    while (!out_val && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [15:0] hq;
    logic [7:0]  hr;
    vecs[0] = '{16'd1000, 8'd7, 16'd142, 8'd6};
    vecs[1] = '{16'd65535, 8'd255, 16'd257, 8'd0};
    vecs[2] = '{16'd5, 8'd9, 16'd0, 8'd5};
    vecs[3] = '{16'h1234, 8'd0, 16'hFFFF, 8'h34};
    vecs[4] = '{16'd300, 8'd10, 16'd30, 8'd0};
    vecs[5] = '{16'd65535, 8'd1, 16'd65535, 8'd0};
    vecs[6] = '{16'd0, 8'd5, 16'd0, 8'd0};
    vecs[7] = '{16'd255, 8'd16, 16'd15, 8'd15};
    vecs[8] = '{16'd40000, 8'd200, 16'd200, 8'd0};
    vecs[9] = '{16'd12345, 8'd123, 16'd100, 8'd45};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_val", out_val, 0);
`ifdef DIVMOD_DIVZERO_FLAG_EN
    chk("rst_divzero", divzero, 0);
`endif
    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].dd, vecs[i].dv, lat);
      chk("latency", lat, 17);
      chk("quot", quot, vecs[i].q);
      chk("rem", rem, vecs[i].r);
      chk("done_in_rdy", in_rdy, 0);
`ifdef DIVMOD_DIVZERO_FLAG_EN
      chk("divzero", divzero, vecs[i].dv == 8'd0);
`endif
      @(negedge clk);
      chk("post_in_rdy", in_rdy, 1);
      chk("post_out_val", out_val, 0);
    end
    out_rdy = 1'b0;
    do_req(16'd1000, 8'd7, lat);
    chk("bp_latency", lat, 17);
    hq = 16'd142;
    hr = 8'd6;
    in_val = 1'b1;
    dividend = 16'd3;
    divisor = 8'd1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_val", out_val, 1);
      chk("bp_quot", quot, hq);
      chk("bp_rem", rem, hr);
      chk("bp_in_rdy", in_rdy, 0);
    end
    in_val = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_rel_in_rdy", in_rdy, 1);
    chk("bp_rel_out_val", out_val, 0);
    @(negedge clk);
    in_val = 1'b1;
    dividend = 16'd1000;
    divisor = 8'd7;
    @(posedge clk);
    @(negedge clk);
    in_val = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_in_rdy", in_rdy, 1);
    chk("mid_rst_out_val", out_val, 0);
    do_req(16'd300, 8'd10, lat);
    chk("after_rst_latency", lat, 17);
    chk("after_rst_quot", quot, 16'd30);
    chk("after_rst_rem", rem, 8'd0);
    @(negedge clk);
    begin
      logic [15:0] qd[$];
      logic [7:0]  qv[$];
      logic [15:0] edd, eq;
      logic [7:0]  edv, er;
      int sent = 0;
      int got = 0;
      int cyc = 0;
      while (got < 1000 && cyc < 60000) begin
        @(negedge clk);
        cyc++;
        in_val = (sent < 1000) && ($urandom_range(3) != 0);
        dividend = 16'($urandom);
        divisor = ($urandom_range(15) == 0) ? 8'd0 : 8'($urandom);
        out_rdy = 1'($urandom_range(1));
        if (in_val && in_rdy) begin
          qd.push_back(dividend);
          qv.push_back(divisor);
          sent++;
        end
        if (out_val && out_rdy) begin
          got++;
          if (qd.size() == 0) chk("rand_unexpected", 1, 0);
          else begin
            edd = qd.pop_front();
            edv = qv.pop_front();
            eq = (edv == 8'd0) ? 16'hFFFF : edd / {8'd0, edv};
            er = (edv == 8'd0) ? edd[7:0] : 8'(edd % {8'd0, edv});
            chk("rand_quot", quot, eq);
            chk("rand_rem", rem, er);
          end
        end
      end
      in_val = 1'b0;
      chk("rand_count", got, 1000);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/iter_divmod_16b8b.md
ITER_DIVMOD_16B8B -- requirements
Module: iter_divmod_16b8b

Interface
REQ-001: clk  input  1  sole clock; all state updates on rising edge.
REQ-002: reset  input  1  synchronous, active-high reset.
REQ-003: in_val  input  1  request valid.
REQ-004: in_rdy  output  1  block ready to accept request.
REQ-005: dividend  input  16  unsigned dividend, sampled on request transfer.
REQ-006: divisor  input  8  unsigned divisor, sampled on request transfer.
REQ-007: out_val  output  1  result valid.
REQ-008: out_rdy  input  1  consumer ready for result.
REQ-009: quot  output  16  unsigned quotient.
REQ-010: rem  output  8  unsigned remainder.
REQ-011: divzero  output  1  divide-by-zero flag; port exists only when DIVMOD_DIVZERO_FLAG_EN is defined.

Function
REQ-012: Block SHALL compute quot and rem such that dividend == quot*divisor + rem, with rem < divisor, for every divisor != 0.
REQ-013: Request transfer SHALL occur on a cycle with in_val && in_rdy; response transfer on a cycle with out_val && out_rdy.
REQ-014: FSM SHALL have states IDLE, CALC, DONE; in_rdy = 1 only in IDLE; out_val = 1 only in DONE.
REQ-015: IDLE -> CALC on request transfer; operands latched into internal registers at that edge.
REQ-016: CALC SHALL last exactly 16 cycles, resolving one quotient bit per cycle, MSB first, by restoring shift-subtract on a partial remainder of at least 17 bits.
REQ-017: CALC -> DONE after the 16th iteration; request transferred at end of cycle N yields out_val = 1 starting cycle N+17.
REQ-018: DONE -> IDLE on response transfer; no new request accepted in the same cycle (in_rdy first high in cycle after transfer).
REQ-019: While out_val && !out_rdy, quot, rem (and divzero) SHALL hold stable indefinitely.
REQ-020: in_val, dividend, divisor SHALL be ignored outside IDLE; operand changes after transfer SHALL not affect the result.
REQ-021: divisor == 0 SHALL yield quot = 16'hFFFF and rem = dividend[7:0], with normal latency and handshake.
REQ-022: quot and rem values outside DONE are don't-care; benches SHALL check them only when out_val = 1.
REQ-023: No combinational path from in_val or out_rdy to in_rdy or out_val.

Reset
REQ-024: reset high at a rising edge SHALL force state IDLE, in_rdy = 1, out_val = 0 from the next cycle, and divzero = 0 when present.
REQ-025: reset asserted during CALC or DONE SHALL abandon the operation; no result for it is ever presented.
REQ-026: reset SHALL take priority over any simultaneous request or response transfer.

Configuration
REQ-027: Macro DIVMOD_DIVZERO_FLAG_EN SHALL control the divide-by-zero flag.
REQ-028: Defined: divzero port present, set in DONE iff latched divisor == 0, 0 otherwise; quot/rem per REQ-021.
REQ-029: Undefined: divzero port and its register absent; all other behaviour identical.

Verification
REQ-030: dividend=1000, divisor=7, out_rdy=1 -> out_val high exactly 17 cycles after transfer, quot=142, rem=6.
REQ-031: dividend=65535, divisor=255 -> quot=257, rem=0; dividend=5, divisor=9 -> quot=0, rem=5.
REQ-032: dividend=16'h1234, divisor=0 -> quot=16'hFFFF, rem=8'h34, divzero=1 when DIVMOD_DIVZERO_FLAG_EN defined.
REQ-033: out_rdy low 5 cycles after out_val rises -> outputs unchanged, in_rdy=0 throughout; in_rdy=1 the cycle after out_rdy raised.
REQ-034: reset pulsed in 8th CALC cycle -> next cycle in_rdy=1, out_val=0; following request 300/10 -> quot=30, rem=0.
REQ-035: 1000 random back-to-back requests with random out_rdy -> every result matches REQ-012 and arrives in request order.
